// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer driven by a one-cycle baud tick.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clock_bps,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_odd,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 txd_q, txd_d;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) parity_q <= 1'b0;
    else          parity_q <= parity_d;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    tx_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ parity_odd;
`endif
          state_d = S_ARM;
        end
      end
      // The accept cycle is spent in IDLE, so a coincident tick never reaches ARM.
      S_ARM: begin
        if (clock_bps) begin
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (clock_bps) begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (clock_bps) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = S_PARITY;
`else
            txd_d      = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (clock_bps) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clock_bps) begin
          if (stop_cnt_q == LAST_STOP) begin
            tx_done = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign txd      = txd_q;
  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - Self-checking bench for uart_tx_serializer (one and two stop bits).
// Expected frames follow UART_TX_PARITY_EN when it is defined.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int NB1 = 11;
`else
  localparam int NB1 = 10;
`endif
  localparam int NB2 = NB1 + 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n = 1'b1;
  logic       clock_bps = 1'b0;
  logic [7:0] d1 = '0, d2 = '0;
  logic       v1 = 1'b0, v2 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic       txd1, rdy1, busy1, done1, txd2, rdy2, busy2, done2;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .clock_bps(clock_bps), .tx_data(d1),
    .tx_valid(v1), .tx_ready(rdy1), .parity_odd(p1), .txd(txd1),
    .tx_busy(busy1), .tx_done(done1));

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .clock_bps(clock_bps), .tx_data(d2),
    .tx_valid(v2), .tx_ready(rdy2), .parity_odd(p2), .txd(txd2),
    .tx_busy(busy2), .tx_done(done2));

  int bps_div = 16;
  int bps_cnt = 0;
  always @(posedge clock) begin
    #2;
    if (bps_div <= 1 || bps_cnt >= bps_div - 1) begin
      clock_bps = 1'b1;
      bps_cnt   = 0;
    end else begin
      clock_bps = 1'b0;
      bps_cnt   = bps_cnt + 1;
    end
  end

  bit   sel = 1'b0;
  logic txd_m, rdy_m, busy_m, done_m;
  assign txd_m  = sel ? txd2  : txd1;
  assign rdy_m  = sel ? rdy2  : rdy1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] data, input logic podd);
    @(negedge clock);
    if (sel) begin d2 = data; p2 = podd; v2 = 1'b1; end
    else     begin d1 = data; p1 = podd; v1 = 1'b1; end
    @(negedge clock);
    if (sel) v2 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_start(output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (txd_m === 1'b0) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  // Samples every cycle of the frame, starting at the first start-bit cycle.
  task automatic capture(input string name, input logic [11:0] exp, input int n,
                         input int d, input bit started);
    logic [11:0] got;
    bit          stable, ok;
    int          dones, done_at, w;
    got = '0; stable = 1'b1; dones = 0; done_at = -1; ok = started;
    if (!started) wait_start(w, ok);
    check({name, "_start"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({name, "_busy"}, 32'(busy_m), 32'd1);
    for (int k = 0; k < n * d; k++) begin
      if (k > 0) @(negedge clock);
      if (k % d == 0) got[k / d] = txd_m;
      else if (txd_m !== got[k / d]) stable = 1'b0;
      if (done_m === 1'b1) begin
        dones++;
        done_at = k;
      end
    end
    check({name, "_bits"}, 32'(got), 32'(exp));
    check({name, "_hold"}, 32'(stable), 32'd1);
    check({name, "_done_cnt"}, 32'(dones), 32'd1);
    check({name, "_done_at"}, 32'(done_at), 32'(n * d - 1));
    @(negedge clock);
    check({name, "_ready"}, 32'(rdy_m), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        podd;
    int          div;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   w, ticks, viol, lows, dones;
    bit   ok;
    logic [11:0] f_a, f_b, f_c, f_d;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 1'b0, 16, 12'({1'b1, 1'b0, 8'h55, 1'b0})};
    vecs[1] = '{8'hA3, 1'b0, 16, 12'({1'b1, 1'b0, 8'hA3, 1'b0})};
    vecs[2] = '{8'hA3, 1'b1, 16, 12'({1'b1, 1'b1, 8'hA3, 1'b0})};
    vecs[3] = '{8'hC6, 1'b0, 1,  12'({1'b1, 1'b0, 8'hC6, 1'b0})};
    vecs[4] = '{8'h81, 1'b1, 4,  12'({1'b1, 1'b1, 8'h81, 1'b0})};
    vecs[5] = '{8'h07, 1'b0, 3,  12'({1'b1, 1'b1, 8'h07, 1'b0})};
    f_a = {2'b11, 1'b0, 8'h00, 1'b0};
    f_b = {2'b11, 1'b0, 8'hFF, 1'b0};
    f_c = 12'({1'b1, 1'b0, 8'h81, 1'b0});
    f_d = 12'({1'b1, 1'b0, 8'hC6, 1'b0});
`else
    vecs[0] = '{8'h55, 1'b0, 16, 12'({1'b1, 8'h55, 1'b0})};
    vecs[1] = '{8'hA3, 1'b0, 16, 12'({1'b1, 8'hA3, 1'b0})};
    vecs[2] = '{8'hA3, 1'b1, 16, 12'({1'b1, 8'hA3, 1'b0})};
    vecs[3] = '{8'hC6, 1'b0, 1,  12'({1'b1, 8'hC6, 1'b0})};
    vecs[4] = '{8'h81, 1'b1, 4,  12'({1'b1, 8'h81, 1'b0})};
    vecs[5] = '{8'h07, 1'b0, 3,  12'({1'b1, 8'h07, 1'b0})};
    f_a = 12'({2'b11, 8'h00, 1'b0});
    f_b = 12'({2'b11, 8'hFF, 1'b0});
    f_c = 12'({1'b1, 8'h81, 1'b0});
    f_d = 12'({1'b1, 8'hC6, 1'b0});
`endif

    #1 reset_n = 1'b0;
    @(negedge clock);
    check("rst_txd", 32'(txd1), 32'd1);
    check("rst_ready", 32'(rdy1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    ticks = 0; viol = 0;
    for (int i = 0; i < 2000 && ticks < 100; i++) begin
      @(negedge clock);
      if (clock_bps === 1'b1) ticks++;
      if (txd1 !== 1'b1 || rdy1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) viol++;
    end
    check("idle_ticks", 32'(ticks), 32'd100);
    check("idle_viol", 32'(viol), 32'd0);

    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bps_div = vecs[i].div;
      send(vecs[i].data, vecs[i].podd);
      capture($sformatf("vec%0d", i), vecs[i].exp, NB1, vecs[i].div, 1'b0);
    end

    sel = 1'b1;
    bps_div = 16;
    fork
      begin
        @(negedge clock);
        d2 = 8'h00; p2 = 1'b0; v2 = 1'b1;
        @(negedge clock);
        d2 = 8'hFF;
        for (int i = 0; i < 600; i++) begin
          @(negedge clock);
          if (rdy2 === 1'b1) break;
        end
        @(negedge clock);
        v2 = 1'b0;
      end
      begin
        capture("b2b_f1", f_a, NB2, 16, 1'b0);
        wait_start(w, ok);
        check("b2b_gap", 32'(w + 1), 32'd16);
        capture("b2b_f2", f_b, NB2, 16, ok);
      end
    join
    lows = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (txd2 !== 1'b1) lows++;
      if (done2 === 1'b1) dones++;
    end
    check("b2b_extra_done", 32'(dones), 32'd0);
    check("b2b_extra_low", 32'(lows), 32'd0);

    sel = 1'b0;
    send(8'h0F, 1'b0);
    wait_start(w, ok);
    check("rst_mid_start", 32'(ok), 32'd1);
    repeat (4 * 16 + 5) @(negedge clock);
    check("rst_mid_bit3", 32'(txd1), 32'd1);
    check("rst_mid_busy", 32'(busy1), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd1), 32'd1);
    check("rst_mid_busy0", 32'(busy1), 32'd0);
    check("rst_mid_ready", 32'(rdy1), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    send(8'h81, 1'b0);
    capture("post_rst", f_c, NB1, 16, 1'b0);

    bps_div = 1;
    send(8'hC6, 1'b0);
    fork
      begin
        repeat (4) @(negedge clock);
        d1 = 8'h3C; v1 = 1'b1;
        @(negedge clock);
        v1 = 1'b0;
      end
      capture("bps1", f_d, NB1, 1, 1'b0);
    join
    lows = 0; dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (txd1 !== 1'b1) lows++;
      if (done1 === 1'b1) dones++;
    end
    check("bps1_no_extra_low", 32'(lows), 32'd0);
    check("bps1_no_extra_done", 32'(dones), 32'd0);
    check("bps1_ready", 32'(rdy1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
